udp_tx: RTL and testbench

Builds UDP/IPv4 frames for the Ethernet transmit path. It holds a host-written 28-byte IPv4+UDP header template and accepts a byte stream of UDP payload whose length arrives on the first beat. It patches the IP total length, UDP length and IP header checksum into the template, then emits header followed by payload on an 8-bit AXI-Stream toward the MAC framer.

---
 rtl/udp_tx.sv | 172 +++++++++++++++++
 tb/tb_udp_tx.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx.sv
// udp_tx: holds a 28-byte IPv4+UDP header template, patches total length,
// UDP length and IP header checksum for each packet, then streams the header
// followed by the UDP payload bytes onto an 8-bit AXI-Stream toward the MAC.
module udp_tx (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Header_wr_en,
  input  logic [2:0]  Header_wr_addr,
  input  logic [31:0] Header_wr_data,
  input  logic [15:0] Udp_length,
  input  logic [7:0]  Udp_data,
  input  logic        Udp_valid,
  input  logic        Udp_last,
  output logic        Udp_ready,
  output logic [7:0]  Mac_payload_data,
  output logic        Mac_payload_valid,
  output logic        Mac_payload_last,
  input  logic        Mac_payload_ready
);

  localparam int Ipv4HdrLen = 20;
  localparam int UdpHdrLen  = 8;
  localparam int HdrLen     = Ipv4HdrLen + UdpHdrLen;

  typedef enum logic [1:0] {IDLE, CALC, HDR, PAY} state_e;

  state_e      state_q, state_d;
  logic [31:0] tmpl_q [0:6];
  logic [15:0] len_q, len_d;
  logic [15:0] totalLen_q, totalLen_d;
  logic [15:0] udpLen_q, udpLen_d;
  logic [15:0] csum_q, csum_d;
  logic [4:0]  byteCnt_q, byteCnt_d;
  logic        inDone_q, inDone_d;
  logic [7:0]  outData_q, outData_d;
  logic        outValid_q, outValid_d;
  logic        outLast_q, outLast_d;

  logic        loadOut;
  logic [31:0] hdrWord;
  logic [7:0]  hdrByte;
  logic [15:0] partialSum;
  logic [15:0] totalLenNext;
  logic [16:0] sumRaw;
  logic [15:0] sumFold;

  // The output register may take a new byte when it is empty or being drained.
  assign loadOut = !outValid_q || Mac_payload_ready;

  // Host partial checksum is stored in network byte order; bring it back to a number.
  assign partialSum   = {tmpl_q[2][23:16], tmpl_q[2][31:24]};
  assign totalLenNext = len_q + 16'(HdrLen);
  assign sumRaw       = {1'b0, partialSum} + {1'b0, totalLenNext};
  assign sumFold      = sumRaw[15:0] + {15'd0, sumRaw[16]};

  assign Mac_payload_data  = outData_q;
  assign Mac_payload_valid = outValid_q;
  assign Mac_payload_last  = outLast_q;

  // Template register file: host writes land only while no frame is in flight; never reset.
  always_ff @(posedge Clk) begin
    if (Header_wr_en && state_q == IDLE && Header_wr_addr != 3'd7) begin
      tmpl_q[Header_wr_addr] <= Header_wr_data;
    end
  end

  // Pick the current header byte, substituting the big-endian patched fields.
  always_comb begin
    hdrWord = tmpl_q[byteCnt_q[4:2]];
    hdrByte = hdrWord[{byteCnt_q[1:0], 3'b000} +: 8];
    case (byteCnt_q)
      5'd2:    hdrByte = totalLen_q[15:8];
      5'd3:    hdrByte = totalLen_q[7:0];
      5'd10:   hdrByte = csum_q[15:8];
      5'd11:   hdrByte = csum_q[7:0];
      5'd24:   hdrByte = udpLen_q[15:8];
      5'd25:   hdrByte = udpLen_q[7:0];
      default: ;
    endcase
  end

  // Next-state logic: sequence IDLE -> CALC -> HDR -> PAY and feed the output register.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    totalLen_d = totalLen_q;
    udpLen_d   = udpLen_q;
    csum_d     = csum_q;
    byteCnt_d  = byteCnt_q;
    inDone_d   = inDone_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    Udp_ready  = 1'b0;

    if (loadOut) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        byteCnt_d = '0;
        inDone_d  = 1'b0;
        if (Udp_valid) begin
          len_d   = Udp_length;
          state_d = CALC;
        end
      end
      CALC: begin
        totalLen_d = totalLenNext;
        udpLen_d   = len_q + 16'(UdpHdrLen);
        csum_d     = ~sumFold;
        state_d    = HDR;
      end
      HDR: begin
        if (loadOut) begin
          outData_d  = hdrByte;
          outValid_d = 1'b1;
          outLast_d  = 1'b0;
          byteCnt_d  = byteCnt_q + 5'd1;
          if (byteCnt_q == 5'(HdrLen - 1)) begin
            state_d = PAY;
          end
        end
      end
      PAY: begin
        Udp_ready = !inDone_q && loadOut;
        if (Udp_ready && Udp_valid) begin
          outData_d  = Udp_data;
          outValid_d = 1'b1;
          outLast_d  = Udp_last;
          if (Udp_last) begin
            inDone_d = 1'b1;
          end
        end
        if (outValid_q && outLast_q && Mac_payload_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      totalLen_q <= '0;
      udpLen_q   <= '0;
      csum_q     <= '0;
      byteCnt_q  <= '0;
      inDone_q   <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      totalLen_q <= totalLen_d;
      udpLen_q   <= udpLen_d;
      csum_q     <= csum_d;
      byteCnt_q  <= byteCnt_d;
      inDone_q   <= inDone_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed and randomized frames through udp_tx with expected
// header bytes, payload and IP checksum produced by the bench.
module tb_udp_tx;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Header_wr_en;
  logic [2:0]  Header_wr_addr;
  logic [31:0] Header_wr_data;
  logic [15:0] Udp_length;
  logic [7:0]  Udp_data;
  logic        Udp_valid;
  logic        Udp_last;
  logic        Udp_ready;
  logic [7:0]  Mac_payload_data;
  logic        Mac_payload_valid;
  logic        Mac_payload_last;
  logic        Mac_payload_ready;

  int          vectorsApplied = 0;
  int          miscompares = 0;
  logic [31:0] tmplModel [0:6];
  logic [7:0]  rxData [$];
  logic        rxLast [$];
  logic [7:0]  lastFrame [$];
  int          readyMode;
  bit          abortTx;
  int          bubbleCount;
  int          gapMax;
  int          idleRun;
  bit          inFrame;

  udp_tx dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .Header_wr_en      (Header_wr_en),
    .Header_wr_addr    (Header_wr_addr),
    .Header_wr_data    (Header_wr_data),
    .Udp_length        (Udp_length),
    .Udp_data          (Udp_data),
    .Udp_valid         (Udp_valid),
    .Udp_last          (Udp_last),
    .Udp_ready         (Udp_ready),
    .Mac_payload_data  (Mac_payload_data),
    .Mac_payload_valid (Mac_payload_valid),
    .Mac_payload_last  (Mac_payload_last),
    .Mac_payload_ready (Mac_payload_ready)
  );

  // Free-running 10-unit clock.
  always #5 Clk = ~Clk;

  // Downstream ready: 0 = held low, 1 = held high, otherwise random at 80%.
  always @(posedge Clk) begin
    #1;
    case (readyMode)
      0:       Mac_payload_ready = 1'b0;
      1:       Mac_payload_ready = 1'b1;
      default: Mac_payload_ready = ($urandom_range(99) < 80);
    endcase
  end

  // Capture every accepted output byte, sampling mid-cycle where signals are settled.
  always @(negedge Clk) begin
    if (Rst_n && Mac_payload_valid && Mac_payload_ready) begin
      rxData.push_back(Mac_payload_data);
      rxLast.push_back(Mac_payload_last);
    end
  end

  // Track bubbles inside a frame and idle cycles before a waiting packet's header appears.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      inFrame = 1'b0;
      idleRun = 0;
    end else begin
      if (Mac_payload_valid) begin
        if (!inFrame && idleRun > gapMax) gapMax = idleRun;
        idleRun = 0;
      end else if (inFrame) begin
        bubbleCount++;
      end else if (Udp_valid) begin
        idleRun++;
      end
      if (Mac_payload_valid && Mac_payload_ready) inFrame = !Mac_payload_last;
    end
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected header byte k for payload length len, from the template model.
  function automatic logic [7:0] modelHdrByte(input int k, input int len);
    logic [15:0] t, u, p, c;
    logic [31:0] s;
    t = 16'(28 + len);
    u = 16'(8 + len);
    p = {tmplModel[2][23:16], tmplModel[2][31:24]};
    s = 32'(p) + 32'(t);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    c = ~s[15:0];
    case (k)
      2:       return t[15:8];
      3:       return t[7:0];
      10:      return c[15:8];
      11:      return c[7:0];
      24:      return u[15:8];
      25:      return u[7:0];
      default: return tmplModel[k / 4][(k % 4) * 8 +: 8];
    endcase
  endfunction

  // Random template whose stored partial checksum matches its own IPv4 words.
  task automatic makeTemplate();
    logic [31:0] sum;
    logic [7:0]  hi, lo;
    for (int i = 0; i < 7; i++) tmplModel[i] = $urandom;
    tmplModel[0][31:16] = 16'h0000;
    tmplModel[2][31:16] = 16'h0000;
    tmplModel[6][15:0]  = 16'h0000;
    sum = 0;
    for (int k = 0; k < 20; k += 2) begin
      hi = tmplModel[k / 4][(k % 4) * 8 +: 8];
      lo = tmplModel[(k + 1) / 4][((k + 1) % 4) * 8 +: 8];
      sum = sum + {16'd0, hi, lo};
    end
    while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    tmplModel[2][31:16] = {sum[7:0], sum[15:8]};
  endtask

  // Write all seven template words from the model into the DUT.
  task automatic loadTemplate();
    for (int i = 0; i < 7; i++) begin
      @(posedge Clk); #1;
      Header_wr_en   = 1'b1;
      Header_wr_addr = 3'(i);
      Header_wr_data = tmplModel[i];
    end
    @(posedge Clk); #1;
    Header_wr_en = 1'b0;
  endtask

  // Drive one UDP packet of len bytes (byte i = seed + 7*i), with optional input gaps.
  task automatic applyStimulus(input int len, input int gapPct, input logic [7:0] seed);
    bit hs;
    int guard;
    abortTx = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < len && !abortTx; i++) begin
      while (gapPct > 0 && $urandom_range(99) < gapPct) begin
        Udp_valid = 1'b0;
        @(posedge Clk); #1;
      end
      Udp_valid  = 1'b1;
      Udp_data   = seed + 8'(i * 7);
      Udp_last   = (i == len - 1);
      Udp_length = (i == 0) ? 16'(len) : 16'hBEEF;
      hs = 1'b0;
      guard = 0;
      while (!hs && !abortTx) begin
        @(negedge Clk);
        hs = Udp_ready && Rst_n;
        @(posedge Clk); #1;
        guard++;
        if (!hs && guard > 4000) begin
          checkOutput("udp beat accepted", 32'd0, 32'd1);
          abortTx = 1'b1;
        end
      end
    end
    Udp_valid = 1'b0;
    Udp_last  = 1'b0;
  endtask

  // Pop one frame from the capture queue and compare it against the model.
  task automatic checkFrame(input int len, input logic [7:0] seed, input bit doCsum, input string tag);
    int n, guard, got, nBad, nLast;
    bit lastEnd, flag;
    logic [7:0]  expByte;
    logic [31:0] sum;
    n = 28 + len;
    guard = 0;
    nBad = 0;
    nLast = 0;
    lastEnd = 1'b0;
    while (rxData.size() < n && guard < 20000) begin
      @(negedge Clk);
      guard++;
    end
    got = (rxData.size() < n) ? rxData.size() : n;
    checkOutput({tag, " frame length"}, 32'(got), 32'(n));
    lastFrame.delete();
    for (int k = 0; k < got; k++) begin
      lastFrame.push_back(rxData.pop_front());
      flag = rxLast.pop_front();
      expByte = (k < 28) ? modelHdrByte(k, len) : seed + 8'((k - 28) * 7);
      if (lastFrame[k] !== expByte) nBad++;
      if (flag) begin
        nLast++;
        if (k == n - 1) lastEnd = 1'b1;
      end
    end
    checkOutput({tag, " wrong bytes"}, 32'(nBad), 32'd0);
    checkOutput({tag, " last count"}, 32'(nLast), 32'd1);
    checkOutput({tag, " last on final byte"}, 32'(lastEnd), 32'd1);
    if (doCsum && got >= 20) begin
      sum = 0;
      for (int k = 0; k < 20; k += 2) sum = sum + {16'd0, lastFrame[k], lastFrame[k + 1]};
      while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      checkOutput({tag, " ip header sum"}, sum, 32'h0000FFFF);
    end
  endtask

  // Freeze downstream ready for several cycles once enough bytes have gone by.
  task automatic stallCheck(input int threshold, input string tag);
    int guard, bad, rdyHigh;
    logic [7:0] d0;
    logic v0, l0;
    guard = 0;
    bad = 0;
    rdyHigh = 0;
    while (rxData.size() < threshold && guard < 1000) begin
      @(posedge Clk);
      guard++;
    end
    @(posedge Clk);
    readyMode = 0;
    @(negedge Clk);
    d0 = Mac_payload_data;
    v0 = Mac_payload_valid;
    l0 = Mac_payload_last;
    checkOutput({tag, " valid while stalled"}, 32'(v0), 32'd1);
    repeat (5) begin
      @(negedge Clk);
      if (Mac_payload_data !== d0 || Mac_payload_valid !== v0 || Mac_payload_last !== l0) bad++;
      if (Udp_ready) rdyHigh++;
    end
    checkOutput({tag, " outputs stable"}, 32'(bad), 32'd0);
    checkOutput({tag, " udp_ready low"}, 32'(rdyHigh), 32'd0);
    readyMode = 1;
  endtask

  // Main sequence: reset, directed frames, stalls, back-to-back, random, reset abort.
  initial begin
    int idleNeg, guard, len;
    logic [7:0] seed;
    Header_wr_en = 1'b0;
    Header_wr_addr = '0;
    Header_wr_data = '0;
    Udp_length = '0;
    Udp_data = '0;
    Udp_valid = 1'b0;
    Udp_last = 1'b0;
    readyMode = 1;
    Mac_payload_ready = 1'b1;
    abortTx = 1'b0;
    bubbleCount = 0;
    gapMax = 0;
    idleRun = 0;
    inFrame = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset valid", 32'(Mac_payload_valid), 32'd0);
    checkOutput("reset last", 32'(Mac_payload_last), 32'd0);
    checkOutput("reset udp_ready", 32'(Udp_ready), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Directed frame: P = 0x1234 stored byte-swapped in word 2 [31:16], L = 1.
    tmplModel[0] = 32'h0000_0045;
    tmplModel[1] = 32'h0000_ABCD;
    tmplModel[2] = 32'h3412_1140;
    tmplModel[3] = 32'h0100_A8C0;
    tmplModel[4] = 32'h0200_A8C0;
    tmplModel[5] = 32'h5000_3930;
    tmplModel[6] = 32'h5A5A_0000;
    loadTemplate();
    fork
      applyStimulus(1, 0, 8'h5A);
      begin
        idleNeg = 0;
        wait (Udp_valid === 1'b1);
        @(negedge Clk);
        while (!Mac_payload_valid && idleNeg < 50) begin
          idleNeg++;
          @(negedge Clk);
        end
        checkOutput("t1 first byte within 3 cycles", 32'(idleNeg <= 3), 32'd1);
      end
    join
    checkFrame(1, 8'h5A, 1'b0, "t1");
    checkOutput("t1 byte0", 32'(lastFrame[0]), 32'h45);
    checkOutput("t1 byte2", 32'(lastFrame[2]), 32'h00);
    checkOutput("t1 byte3", 32'(lastFrame[3]), 32'h1D);
    checkOutput("t1 byte10", 32'(lastFrame[10]), 32'hED);
    checkOutput("t1 byte11", 32'(lastFrame[11]), 32'hAE);
    checkOutput("t1 byte24", 32'(lastFrame[24]), 32'h00);
    checkOutput("t1 byte25", 32'(lastFrame[25]), 32'h09);
    checkOutput("t1 byte26", 32'(lastFrame[26]), 32'h5A);
    checkOutput("t1 byte28", 32'(lastFrame[28]), 32'h5A);

    // Carry fold: P = 0xFFF0, L = 100 gives T = 0x0080, C = 0xFF8E, U = 0x006C.
    tmplModel[2] = 32'hF0FF_1140;
    loadTemplate();
    applyStimulus(100, 0, 8'h01);
    checkFrame(100, 8'h01, 1'b0, "t2");
    checkOutput("t2 byte2", 32'(lastFrame[2]), 32'h00);
    checkOutput("t2 byte3", 32'(lastFrame[3]), 32'h80);
    checkOutput("t2 byte10", 32'(lastFrame[10]), 32'hFF);
    checkOutput("t2 byte11", 32'(lastFrame[11]), 32'h8E);
    checkOutput("t2 byte24", 32'(lastFrame[24]), 32'h00);
    checkOutput("t2 byte25", 32'(lastFrame[25]), 32'h6C);

    // Downstream stalls in the middle of the header and of the payload.
    fork
      applyStimulus(20, 0, 8'h33);
      begin
        stallCheck(5, "hdr");
        stallCheck(35, "pay");
      end
    join
    checkFrame(20, 8'h33, 1'b0, "stall");

    // Back-to-back packets with ready high: no bubbles, short inter-frame gap.
    bubbleCount = 0;
    gapMax = 0;
    idleRun = 0;
    applyStimulus(1, 0, 8'h10);
    applyStimulus(2, 0, 8'h20);
    applyStimulus(60, 0, 8'h30);
    checkFrame(1, 8'h10, 1'b0, "b2b0");
    checkFrame(2, 8'h20, 1'b0, "b2b1");
    checkFrame(60, 8'h30, 1'b0, "b2b2");
    checkOutput("b2b bubbles inside frames", 32'(bubbleCount), 32'd0);
    checkOutput("b2b gap within 3 cycles", 32'(gapMax <= 3), 32'd1);

    // Random templates, input gaps and downstream backpressure.
    readyMode = 2;
    for (int p = 0; p < 100; p++) begin
      if (p % 10 == 0) begin
        makeTemplate();
        loadTemplate();
      end
      len  = (p == 50) ? 1400 : int'($urandom_range(300, 1));
      seed = 8'($urandom);
      applyStimulus(len, 10, seed);
      checkFrame(len, seed, 1'b1, $sformatf("rand%0d", p));
    end

    // Reset in the middle of the payload, then a fresh packet from the retained template.
    readyMode = 1;
    fork
      applyStimulus(50, 0, 8'h77);
      begin
        guard = 0;
        while (rxData.size() < 40 && guard < 1000) begin
          @(posedge Clk);
          guard++;
        end
        @(posedge Clk); #1;
        abortTx = 1'b1;
        Rst_n = 1'b0;
        @(negedge Clk);
        checkOutput("abort valid", 32'(Mac_payload_valid), 32'd0);
        checkOutput("abort udp_ready", 32'(Udp_ready), 32'd0);
      end
    join
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    rxData.delete();
    rxLast.delete();
    applyStimulus(5, 0, 8'hC3);
    checkFrame(5, 8'hC3, 1'b1, "after reset");

    repeat (10) @(negedge Clk);
    checkOutput("no stray output bytes", 32'(rxData.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
